// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
// Digit-serial packed-BCD adder controller. One shared 4-bit add/correct
// stage is stepped across the operand digits, least-significant first, with
// the decimal carry rippled between digits. One digit is processed per clock.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for start; operands are latched on the accepting edge
//   ADD   | one digit per edge; down-counter cnt reaches 0 on the last digit
//   DONE  | done pulses for this single cycle; sum/cout were just updated
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;

    // Working copies of the operands shift right so the active digit is
    // always in bits [3:0]; the result shifts in from the top so that after
    // DIGITS steps digit 0 sits at the bottom.
    logic [W-1:0]   a_w;
    logic [W-1:0]   b_w;
    logic [W-1:0]   res_w;
    logic           carry;
    logic [IW-1:0]  cnt;

    logic [4:0]     t;
    logic [3:0]     digit;
    logic           c_next;
    logic [W-1:0]   res_next;
    logic           bad_digit;

    // Single-digit add with decimal correction; invalid digits follow the
    // same rule so the result is deterministic rather than saturated.
    always_comb begin
        t        = {1'b0, a_w[3:0]} + {1'b0, b_w[3:0]} + {4'b0000, carry};
        digit    = t[3:0];
        c_next   = 1'b0;
        if (t > 5'd9) begin
            digit  = t[3:0] + 4'd6;
            c_next = 1'b1;
        end
        res_next = (res_w >> 4) | (W'(digit) << (W - 4));
    end

    // Flags any operand digit outside 0..9 at the moment of acceptance.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Sequencer with registered outputs; sum/cout only move on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_w   <= '0;
            b_w   <= '0;
            res_w <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_w   <= a;
                        b_w   <= b;
                        res_w <= '0;
                        carry <= 1'b0;
                        cnt   <= IW'(DIGITS - 1);
                        err   <= bad_digit;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    a_w   <= a_w >> 4;
                    b_w   <= b_w >> 4;
                    carry <= c_next;
                    res_w <= res_next;
                    if (cnt == '0) begin
                        sum   <= res_next;
                        cout  <= c_next;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - IW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
